// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Multi-cycle program sequencer for the single-issue datapath. It owns the
// program counter, steps through instructions, stalls loads and stores for
// the data-memory latency, resolves taken branches and stops on halt.
//
// Parameters
//   PCW      program counter width (instruction memory depth 2**PCW)
//   MEM_LAT  extra wait cycles for a load/store (0..7); 0 = single-cycle memory
//   CNTW     width of the cycle and instruction performance counters
//
// Ports
//   Clk        in   clock, all state updates on the rising edge
//   Reset      in   synchronous active-high reset, overrides every other input
//   Start      in   begin execution at StartAddr (only from IDLE or HALTED)
//   StartAddr  in   first instruction address
//   Branch     in   current instruction is a conditional branch
//   BrTaken    in   ALU branch condition for the current instruction
//   Target     in   absolute branch target for the current instruction
//   Halt       in   current instruction is a halt
//   MemtoReg   in   current instruction is a load
//   MemWrite   in   current instruction is a store
//   ProgCtr    out  address of the current instruction (registered)
//   Commit     out  current instruction retires this cycle (combinational);
//                   gates the register-file and data-memory write enables
//   Busy       out  sequencer is in EXEC or MEMWAIT
//   Done       out  sequencer is in HALTED
//   CycleCnt   out  cycles spent in EXEC/MEMWAIT since the last Start
//   InstrCnt   out  committed instructions since the last Start (halt excluded)
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int PCW     = 10,
  parameter int MEM_LAT = 2,
  parameter int CNTW    = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [PCW-1:0]  StartAddr,
  input  logic            Branch,
  input  logic            BrTaken,
  input  logic [PCW-1:0]  Target,
  input  logic            Halt,
  input  logic            MemtoReg,
  input  logic            MemWrite,
  output logic [PCW-1:0]  ProgCtr,
  output logic            Commit,
  output logic            Busy,
  output logic            Done,
  output logic [CNTW-1:0] CycleCnt,
  output logic [CNTW-1:0] InstrCnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC    = 2'd1,
    S_MEMWAIT = 2'd2,
    S_HALTED  = 2'd3
  } state_e;

  // A memory op with MEM_LAT extra cycles spends MEM_LAT cycles with the
  // wait counter counting MEM_LAT-1 down to 0 in MEMWAIT after its EXEC cycle.
  localparam bit        HAS_LAT   = (MEM_LAT > 0);
  localparam logic [2:0] WAIT_INIT = HAS_LAT ? 3'(MEM_LAT - 1) : 3'd0;

  state_e          state_q;
  logic [PCW-1:0]  pc_q;
  logic [2:0]      wait_q;
  logic [CNTW-1:0] cyc_q;
  logic [CNTW-1:0] ins_q;

  logic            mem_op;
  logic            commit_c;
  logic [PCW-1:0]  pc_step_d;

  // Performance counters stick at all-ones instead of wrapping.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  assign mem_op = MemtoReg | MemWrite;

  // Address taken on commit; the +1 wraps naturally at 2**PCW.
  assign pc_step_d = (Branch & BrTaken) ? Target : pc_q + PCW'(1);

  // Commit depends only on state, wait counter and the decode inputs, so the
  // write enables it gates see it in the same cycle as the instruction.
  always_comb begin
    commit_c = 1'b0;
    case (state_q)
      S_EXEC:    commit_c = !Halt && !(mem_op && HAS_LAT);
      S_MEMWAIT: commit_c = (wait_q == 3'd0);
      default:   commit_c = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      wait_q  <= '0;
      cyc_q   <= '0;
      ins_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_HALTED: begin
          if (Start) begin
            pc_q    <= StartAddr;
            wait_q  <= '0;
            cyc_q   <= '0;
            ins_q   <= '0;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          cyc_q <= sat_inc(cyc_q);
          if (Halt) begin
            // Halt wins over branch and memory flags; PC stays on the halt.
            state_q <= S_HALTED;
          end else if (mem_op && HAS_LAT) begin
            wait_q  <= WAIT_INIT;
            state_q <= S_MEMWAIT;
          end else begin
            ins_q <= sat_inc(ins_q);
            pc_q  <= pc_step_d;
          end
        end
        S_MEMWAIT: begin
          cyc_q <= sat_inc(cyc_q);
          if (wait_q != 3'd0) begin
            wait_q <= wait_q - 3'd1;
          end else begin
            // Decode inputs are re-presented, so a branch carried on a
            // memory op resolves here at its commit.
            ins_q   <= sat_inc(ins_q);
            pc_q    <= pc_step_d;
            state_q <= S_EXEC;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ProgCtr  = pc_q;
  assign Commit   = commit_c;
  assign Busy     = (state_q == S_EXEC) || (state_q == S_MEMWAIT);
  assign Done     = (state_q == S_HALTED);
  assign CycleCnt = cyc_q;
  assign InstrCnt = ins_q;

`ifndef SYNTHESIS
  a_no_commit_idle: assert property (@(posedge Clk)
    (state_q == S_IDLE || state_q == S_HALTED) |-> !commit_c);
  a_busy_done_excl: assert property (@(posedge Clk) !(Busy && Done));
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a default instance (PCW=10, MEM_LAT=2,
// CNTW=16) and a small instance (PCW=4, MEM_LAT=0, CNTW=4) for PC wrap,
// single-cycle memory and counter saturation.
module tb_pc_sequencer;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  // default instance
  logic        rst, start, br, tk, hlt, ld, st;
  logic [9:0]  start_addr, tgt;
  logic [9:0]  pc;
  logic        commit, busy, done;
  logic [15:0] cyc, ins;

  // small instance
  logic        s_rst, s_start, s_br, s_tk, s_hlt, s_ld, s_st;
  logic [3:0]  s_addr, s_tgt;
  logic [3:0]  s_pc;
  logic        s_commit, s_busy, s_done;
  logic [3:0]  s_cyc, s_ins;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer #(.PCW(10), .MEM_LAT(2), .CNTW(16)) u_dut (
    .Clk(Clk), .Reset(rst), .Start(start), .StartAddr(start_addr),
    .Branch(br), .BrTaken(tk), .Target(tgt), .Halt(hlt),
    .MemtoReg(ld), .MemWrite(st), .ProgCtr(pc), .Commit(commit),
    .Busy(busy), .Done(done), .CycleCnt(cyc), .InstrCnt(ins)
  );

  pc_sequencer #(.PCW(4), .MEM_LAT(0), .CNTW(4)) u_small (
    .Clk(Clk), .Reset(s_rst), .Start(s_start), .StartAddr(s_addr),
    .Branch(s_br), .BrTaken(s_tk), .Target(s_tgt), .Halt(s_hlt),
    .MemtoReg(s_ld), .MemWrite(s_st), .ProgCtr(s_pc), .Commit(s_commit),
    .Busy(s_busy), .Done(s_done), .CycleCnt(s_cyc), .InstrCnt(s_ins)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic dec(input logic b, input logic t, input logic [9:0] a,
                     input logic h, input logic l, input logic s);
    br = b; tk = t; tgt = a; hlt = h; ld = l; st = s;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0;
    dec(0, 0, 10'd0, 0, 0, 0);
    s_rst = 1'b1; s_start = 1'b0; s_addr = '0;
    s_br = 1'b0; s_tk = 1'b0; s_tgt = '0; s_hlt = 1'b0; s_ld = 1'b0; s_st = 1'b0;

    // reset state
    tick(); tick(); settle();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_commit", 32'(commit), 0);
    chk("rst_cyc", 32'(cyc), 0);
    chk("rst_ins", 32'(ins), 0);

    // start at 5, three ALU ops
    rst = 1'b0; start = 1'b1; start_addr = 10'd5;
    tick(); start = 1'b0; settle();
    chk("t1_pc5", 32'(pc), 5);
    chk("t1_commit5", 32'(commit), 1);
    chk("t1_busy", 32'(busy), 1);
    tick(); settle();
    chk("t1_pc6", 32'(pc), 6);
    chk("t1_commit6", 32'(commit), 1);
    tick(); settle();
    chk("t1_pc7", 32'(pc), 7);
    tick(); settle();
    chk("t1_pc8", 32'(pc), 8);
    chk("t1_ins", 32'(ins), 3);
    chk("t1_cyc", 32'(cyc), 3);
    chk("t1_done", 32'(done), 0);

    // taken branch 8->2, taken 2->8, not taken 8->9
    dec(1, 1, 10'd2, 0, 0, 0); settle();
    chk("t2_commit_br", 32'(commit), 1);
    tick(); settle();
    chk("t2_pc_taken", 32'(pc), 2);
    dec(1, 1, 10'd8, 0, 0, 0);
    tick(); dec(1, 0, 10'd2, 0, 0, 0); settle();
    chk("t2_pc_back8", 32'(pc), 8);
    tick(); settle();
    chk("t2_pc_nottaken", 32'(pc), 9);

    // branch to 4, load with MEM_LAT=2
    dec(1, 1, 10'd4, 0, 0, 0);
    tick(); dec(0, 0, 10'd0, 0, 1, 0); settle();
    chk("t3_pc4_c0", 32'(pc), 4);
    chk("t3_commit_c0", 32'(commit), 0);
    tick(); settle();
    chk("t3_pc4_c1", 32'(pc), 4);
    chk("t3_commit_c1", 32'(commit), 0);
    chk("t3_busy_wait", 32'(busy), 1);
    tick(); settle();
    chk("t3_pc4_c2", 32'(pc), 4);
    chk("t3_commit_c2", 32'(commit), 1);
    tick(); dec(0, 0, 10'd0, 0, 0, 0); settle();
    chk("t3_pc5", 32'(pc), 5);
    chk("t3_ins", 32'(ins), 8);
    chk("t3_cyc", 32'(cyc), 10);

    // store carrying a taken branch: memory timing, branch at commit
    dec(1, 1, 10'd10, 0, 0, 1); settle();
    chk("t3s_commit_c0", 32'(commit), 0);
    tick(); settle();
    chk("t3s_pc_c1", 32'(pc), 5);
    chk("t3s_commit_c1", 32'(commit), 0);
    tick(); settle();
    chk("t3s_commit_c2", 32'(commit), 1);
    tick(); dec(0, 0, 10'd0, 0, 0, 0); settle();
    chk("t3s_pc10", 32'(pc), 10);

    // halt (with load flag, halt wins)
    dec(0, 0, 10'd0, 1, 1, 0); settle();
    chk("t4_commit_halt", 32'(commit), 0);
    tick(); settle();
    chk("t4_done", 32'(done), 1);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_pc", 32'(pc), 10);
    chk("t4_cyc", 32'(cyc), 14);
    chk("t4_ins", 32'(ins), 9);
    chk("t4_commit_halted", 32'(commit), 0);
    tick(); settle();
    chk("t4_pc_frozen", 32'(pc), 10);
    chk("t4_cyc_frozen", 32'(cyc), 14);
    start = 1'b1; start_addr = 10'd0;
    tick(); start = 1'b0; dec(0, 0, 10'd0, 0, 0, 0); settle();
    chk("t4_restart_pc", 32'(pc), 0);
    chk("t4_restart_done", 32'(done), 0);
    chk("t4_restart_cyc", 32'(cyc), 0);
    chk("t4_restart_ins", 32'(ins), 0);

    // reset in MEMWAIT with ctr=1, Start held with Reset
    dec(0, 0, 10'd0, 0, 1, 0);
    tick();
    rst = 1'b1; start = 1'b1; start_addr = 10'd7; settle();
    chk("t6_commit_wait", 32'(commit), 0);
    chk("t6_busy_wait", 32'(busy), 1);
    tick(); settle();
    chk("t6_busy", 32'(busy), 0);
    chk("t6_pc", 32'(pc), 0);
    chk("t6_cyc", 32'(cyc), 0);
    chk("t6_ins", 32'(ins), 0);
    chk("t6_commit", 32'(commit), 0);
    tick(); settle();
    chk("t6_held_busy", 32'(busy), 0);
    chk("t6_held_pc", 32'(pc), 0);
    rst = 1'b0; dec(0, 0, 10'd0, 0, 0, 0);
    tick(); settle();
    chk("t6_start_pc", 32'(pc), 7);
    chk("t6_start_busy", 32'(busy), 1);
    start_addr = 10'd3;
    tick(); settle();
    chk("t6_start_ignored", 32'(pc), 8);
    start = 1'b0;

    // small instance: PC wrap, single-cycle load, counter saturation
    s_rst = 1'b0; s_start = 1'b1; s_addr = 4'd13;
    tick(); s_start = 1'b0; settle();
    chk("t5_pc13", 32'(s_pc), 13);
    chk("t5_commit13", 32'(s_commit), 1);
    tick(); settle();
    chk("t5_pc14", 32'(s_pc), 14);
    tick(); settle();
    chk("t5_pc15", 32'(s_pc), 15);
    tick(); settle();
    chk("t5_pc_wrap", 32'(s_pc), 0);
    chk("t5_ins3", 32'(s_ins), 3);
    s_ld = 1'b1; settle();
    chk("t5_load_commit", 32'(s_commit), 1);
    tick(); s_ld = 1'b0; settle();
    chk("t5_load_pc", 32'(s_pc), 1);
    chk("t5_ins4", 32'(s_ins), 4);
    for (int i = 0; i < 16; i++) tick();
    settle();
    chk("t5_ins_sat", 32'(s_ins), 15);
    chk("t5_cyc_sat", 32'(s_cyc), 15);
    chk("t5_pc_final", 32'(s_pc), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
